// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the processor has fixed priority; a single buffered host
// access takes idle memory cycles and is forced through after STARVE_LIMIT denials.
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_mem_read,
  input  logic          cpu_mem_write,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ready,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [15:0]   stall_count
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("dmem_arbiter: STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state;
  logic [3:0]    starve_cnt;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic [15:0]   stall_cnt_q;
  logic          cpu_act;
  logic          host_win;

  assign cpu_act  = cpu_mem_read | cpu_mem_write;
  assign host_win = (state == ST_WAIT) &&
                    (!cpu_act || (starve_cnt == 4'(STARVE_LIMIT)));

  // Exactly one requester owns the memory port in any cycle.
  assign mem_read    = host_win ? !buf_we   : cpu_mem_read;
  assign mem_write   = host_win ? buf_we    : cpu_mem_write;
  assign mem_addr    = host_win ? buf_addr  : cpu_addr;
  assign mem_din     = host_win ? buf_wdata : cpu_din;
  assign cpu_dout    = mem_dout;
  assign cpu_stall   = host_win & cpu_act;
  assign host_ready  = (state == ST_IDLE);
  assign stall_count = stall_cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      starve_cnt  <= '0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          starve_cnt <= '0;
          if (host_req) begin
            buf_we    <= host_we;
            buf_addr  <= host_addr;
            buf_wdata <= host_wdata;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (host_win) begin
            starve_cnt <= '0;
            state      <= ST_IDLE;
            if (!buf_we) begin
              host_rdata  <= mem_dout;
              host_rvalid <= 1'b1;
            end
          end else begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (cpu_stall && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-indexed memory model.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_mem_read, cpu_mem_write;
  logic [31:0] cpu_addr, cpu_din, cpu_dout;
  logic        cpu_stall;
  logic        host_req, host_we;
  logic [31:0] host_addr, host_wdata;
  logic        host_ready;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem [0:15];

  always #5 clock = ~clock;

  assign mem_dout = mem[mem_addr[5:2]];
  always @(posedge clock) if (mem_write) mem[mem_addr[5:2]] <= mem_din;

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall_count(stall_count)
  );

  // Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_mem_read = 1'b1; cpu_mem_write = 1'b0; cpu_addr = 32'h20; cpu_din = 32'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 32'h0; host_wdata = 32'h0;
    #2;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", host_ready); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b exp 0", cpu_stall); end
    checks++; if (host_rvalid !== 1'b0 || host_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %b/%h exp 0/0", host_rvalid, host_rdata); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h exp 0", stall_count); end
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL rst_cpu_path: got %b/%h exp 1/20", mem_read, mem_addr); end
    step(); step();
    reset = 1'b0; cpu_mem_read = 1'b0;
    step();
  endtask

  task automatic test_host_read_idle();
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'h4;
    #1;
    checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", host_ready); end
    step();
    host_req = 1'b0; #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'h4 || host_ready !== 1'b0) begin errors++; $display("FAIL rd_service: got rd=%b addr=%h rdy=%b exp 1/4/0", mem_read, mem_addr, host_ready); end
    checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rd_nostall: got %b exp 0", cpu_stall); end
    step(); #1;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h8) begin errors++; $display("FAIL rd_rvalid: got %b/%h exp 1/8", host_rvalid, host_rdata); end
    checks++; if (mem_read !== 1'b0 || host_ready !== 1'b1) begin errors++; $display("FAIL rd_idle: got rd=%b rdy=%b exp 0/1", mem_read, host_ready); end
    step(); #1;
    checks++; if (host_rvalid !== 1'b0 || stall_count !== 16'h0) begin errors++; $display("FAIL rd_pulse: got rv=%b cnt=%h exp 0/0", host_rvalid, stall_count); end
  endtask

  task automatic test_starvation();
    cpu_mem_read = 1'b1; cpu_addr = 32'h0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h8; host_wdata = 32'h55;
    step();
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (cpu_stall !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL starve_deny%0d: got st=%b wr=%b addr=%h exp 0/0/0", i, cpu_stall, mem_write, mem_addr); end
      step();
    end
    #1;
    checks++; if (cpu_stall !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0) begin errors++; $display("FAIL starve_force: got st=%b wr=%b rd=%b exp 1/1/0", cpu_stall, mem_write, mem_read); end
    checks++; if (mem_addr !== 32'h8 || mem_din !== 32'h55) begin errors++; $display("FAIL starve_bus: got %h/%h exp 8/55", mem_addr, mem_din); end
    step();
    cpu_addr = 32'h8; #1;
    checks++; if (cpu_stall !== 1'b0 || host_ready !== 1'b1 || host_rvalid !== 1'b0) begin errors++; $display("FAIL starve_after: got st=%b rdy=%b rv=%b exp 0/1/0", cpu_stall, host_ready, host_rvalid); end
    checks++; if (cpu_dout !== 32'h55 || stall_count !== 16'd1) begin errors++; $display("FAIL starve_readback: got %h cnt=%0d exp 55/1", cpu_dout, stall_count); end
    cpu_mem_read = 1'b0;
    step();
  endtask

  task automatic test_gap();
    cpu_mem_write = 1'b1; cpu_addr = 32'h3C; cpu_din = 32'hDEAD;
    host_req = 1'b1; host_we = 1'b0; host_addr = 32'hC;
    step();
    host_req = 1'b0; #1;
    checks++; if (mem_write !== 1'b1 || mem_addr !== 32'h3C || cpu_stall !== 1'b0) begin errors++; $display("FAIL gap_cpu: got wr=%b addr=%h st=%b exp 1/3c/0", mem_write, mem_addr, cpu_stall); end
    step();
    cpu_mem_write = 1'b0; #1;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'hC || cpu_stall !== 1'b0) begin errors++; $display("FAIL gap_serve: got rd=%b addr=%h st=%b exp 1/c/0", mem_read, mem_addr, cpu_stall); end
    step();
    cpu_mem_write = 1'b1; #1;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h7) begin errors++; $display("FAIL gap_rdata: got %b/%h exp 1/7", host_rvalid, host_rdata); end
    // A fresh request must again see the full four denials if starve_cnt was cleared.
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h30; host_wdata = 32'h1;
    step();
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL gap_recount%0d: got %b exp 0", i, cpu_stall); end
      step();
    end
    #1;
    checks++; if (cpu_stall !== 1'b1 || mem_addr !== 32'h30) begin errors++; $display("FAIL gap_reforce: got %b/%h exp 1/30", cpu_stall, mem_addr); end
    step();
    cpu_mem_write = 1'b0; #1;
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL gap_cnt: got %0d exp 2", stall_count); end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] vals  [3];
    addrs = '{32'h4, 32'h8, 32'hC};
    vals  = '{32'h8, 32'h9, 32'h7};
    mem[2] = 32'h9;
    host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_addr = addrs[i]; #1;
      checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b exp 1", i, host_ready); end
      if (i > 0) begin
        checks++; if (host_rvalid !== 1'b1 || host_rdata !== vals[i-1]) begin errors++; $display("FAIL b2b_rdata%0d: got %b/%h exp 1/%h", i-1, host_rvalid, host_rdata, vals[i-1]); end
      end
      step();
      host_addr = 32'h3C; #1;
      checks++; if (host_ready !== 1'b0 || host_rvalid !== 1'b0 || mem_addr !== addrs[i]) begin errors++; $display("FAIL b2b_serve%0d: got rdy=%b rv=%b addr=%h exp 0/0/%h", i, host_ready, host_rvalid, mem_addr, addrs[i]); end
      step();
    end
    host_req = 1'b0; #1;
    checks++; if (host_rvalid !== 1'b1 || host_rdata !== 32'h7) begin errors++; $display("FAIL b2b_last: got %b/%h exp 1/7", host_rvalid, host_rdata); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    mem[4] = 32'h0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 32'h10; host_wdata = 32'hAA;
    step();
    host_req = 1'b0; #1;
    reset = 1'b1; #1;
    checks++; if (host_ready !== 1'b1 || mem_write !== 1'b0 || host_rvalid !== 1'b0) begin errors++; $display("FAIL rstw_now: got rdy=%b wr=%b rv=%b exp 1/0/0", host_ready, mem_write, host_rvalid); end
    step();
    reset = 1'b0; #1;
    checks++; if (mem[4] !== 32'h0 || mem_write !== 1'b0) begin errors++; $display("FAIL rstw_dropped: got mem=%h wr=%b exp 0/0", mem[4], mem_write); end
    checks++; if (stall_count !== 16'h0) begin errors++; $display("FAIL rstw_cnt: got %h exp 0", stall_count); end
    step();
  endtask

  task automatic test_saturation();
    // Preload the counter near the top so saturation is reached in a few stalls.
    force dut.stall_cnt_q = 16'hFFFA;
    #1;
    release dut.stall_cnt_q;
    step();
    cpu_mem_read = 1'b1; cpu_addr = 32'h0;
    for (int s = 1; s <= 7; s++) begin
      host_req = 1'b1; host_we = 1'b1; host_addr = 32'h34; host_wdata = 32'(s);
      step();
      host_req = 1'b0;
      repeat (5) step();
      #1;
      if (s == 5) begin
        checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h exp ffff", stall_count); end
      end
    end
    #1;
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h exp ffff", stall_count); end
    cpu_mem_read = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[1] = 32'h8; mem[3] = 32'h7;
    test_reset();
    test_host_read_idle();
    test_starvation();
    test_gap();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
